// File: rtl/sd_card_cmd_responder_if.sv
// Card-logic side of the SD CMD responder: decoded command out, response request in.
// The card logic uses the master modport, the responder the slave modport.
interface sd_card_cmd_responder_if;
    logic        cmd_strobe_out;
    logic        cmd_ack_in;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_error;
    logic        resp_strobe_in;
    logic        resp_none;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_ack_out;

    modport master (
        input  cmd_strobe_out, cmd_index, cmd_arg, cmd_error, resp_ack_out,
        output cmd_ack_in, resp_strobe_in, resp_none, resp_index, resp_arg
    );

    modport slave (
        output cmd_strobe_out, cmd_index, cmd_arg, cmd_error, resp_ack_out,
        input  cmd_ack_in, resp_strobe_in, resp_none, resp_index, resp_arg
    );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit command frames, checks CRC7 and
// framing, hands them to card logic, then serialises the 48-bit response after NCR.
module sd_card_cmd_responder #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                          sd_clock,
    input  logic                          reset,
    input  logic                          cmd_in,
    output logic                          cmd_out,
    output logic                          cmd_oe,
    input  logic                          abort_in,
    output logic                          busy,
    sd_card_cmd_responder_if.slave        card
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RX_LAST      = CNT_W'(46);
    localparam logic [CNT_W-1:0] TX_LAST      = CNT_W'(47);
    localparam logic [CNT_W-1:0] NCR_LAST     = CNT_W'(NCR - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECEIVE,
        S_CHECK,
        S_DELIVER,
        S_WAIT_RESP,
        S_NCR,
        S_SEND,
        S_DONE
    } state_t;

    // CRC7, polynomial x^7 + x^3 + 1, zero init, fed MSB first.
    function automatic logic [6:0] crc7_40(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    state_t            state_q, state_d;
    logic [47:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        cmd_index_q, cmd_index_d;
    logic [31:0]       cmd_arg_q, cmd_arg_d;
    logic [5:0]        resp_index_q, resp_index_d;
    logic [31:0]       resp_arg_q, resp_arg_d;

    logic [6:0]        rx_crc;
    logic              frame_bad;
    logic [39:0]       tx_head;
    logic [47:0]       tx_frame;

    // shreg_q[47] is the start bit once a frame is fully shifted in.
    assign rx_crc    = crc7_40(shreg_q[47:8]);
    assign frame_bad = !shreg_q[46] || !shreg_q[0] || (rx_crc != shreg_q[7:1]);

    assign tx_head   = {2'b00, resp_index_q, resp_arg_q};
    assign tx_frame  = {tx_head, crc7_40(tx_head), 1'b1};

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        resp_index_d = resp_index_q;
        resp_arg_d   = resp_arg_q;

        if (abort_in && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!cmd_in) begin
                        shreg_d = {shreg_q[46:0], cmd_in};
                        state_d = S_RECEIVE;
                    end
                end
                S_RECEIVE: begin
                    shreg_d = {shreg_q[46:0], cmd_in};
                    if (cnt_q == RX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (frame_bad) begin
                        state_d = S_IDLE;
                    end else begin
                        cmd_index_d = shreg_q[45:40];
                        cmd_arg_d   = shreg_q[39:8];
                        state_d     = S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (card.cmd_ack_in) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (card.resp_strobe_in) begin
                        resp_index_d = card.resp_index;
                        resp_arg_d   = card.resp_arg;
                        cnt_d        = '0;
                        state_d      = card.resp_none ? S_DONE : S_NCR;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_NCR: begin
                    if (cnt_q == NCR_LAST) begin
                        shreg_d = tx_frame;
                        cnt_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    shreg_d = {shreg_q[46:0], 1'b1};
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            resp_index_q <= resp_index_d;
            resp_arg_q   <= resp_arg_d;
        end
    end

    // All outputs decode registered state; abort suppresses the pulse outputs.
    assign cmd_oe              = (state_q == S_SEND);
    assign cmd_out             = cmd_oe ? shreg_q[47] : 1'b1;
    assign busy                = (state_q != S_IDLE);
    assign card.cmd_strobe_out = (state_q == S_DELIVER);
    assign card.cmd_error      = (state_q == S_CHECK) && frame_bad && !abort_in;
    assign card.resp_ack_out   = (state_q == S_DONE) && !abort_in;
    assign card.cmd_index      = cmd_index_q;
    assign card.cmd_arg        = cmd_arg_q;

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
Card-side end of the SD CMD line: the responder that answers the host's command/response physical layer. It deserialises 48-bit command frames from the CMD pin, checks framing and CRC7, and hands index/argument to the card logic with a strobe/ack handshake. After the card logic supplies a response, it waits the NCR gap and serialises a 48-bit response frame with a computed CRC7. Used as the synthesizable card model behind the host CMD block and as the CMD front-end of card-side designs.

Parameters:
NCR, 2, idle cycles (cmd_oe=0, cmd_out=1) between response acceptance and the response start bit; legal range 2..64.
RESP_TIMEOUT, 64, cycles allowed in WAIT_RESP before the command is abandoned.

Ports:
sd_clock  input  1  card clock; all logic on posedge.
reset  input  1  synchronous, active-high.
cmd_in  input  1  sampled CMD pin (idle high).
cmd_out  output  1  CMD pin drive value.
cmd_oe  output  1  1 = drive pin, 0 = release.
abort_in  input  1  force return to IDLE.
cmd_strobe_out  output  1  valid command available.
cmd_ack_in  input  1  card logic accepted command.
cmd_index  output  6  received command index.
cmd_arg  output  32  received argument.
cmd_error  output  1  one-cycle pulse on CRC/framing error.
resp_strobe_in  input  1  card logic response request.
resp_none  input  1  with resp_strobe_in: no response frame to send.
resp_index  input  6  response index/header field.
resp_arg  input  32  response payload.
resp_ack_out  output  1  one-cycle pulse: response finished or skipped.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, any state): state=IDLE; cmd_out=1, cmd_oe=0, cmd_strobe_out=0, cmd_index=0, cmd_arg=0, cmd_error=0, resp_ack_out=0, busy=0; shift register, CRC and counters cleared. Mid-frame reset drops the frame; cmd_oe falls at that edge.
- abort_in=1 in any non-IDLE state: next state IDLE, cmd_oe=0, no strobe/ack/error pulse. reset has priority over abort_in.
- Frame (MSB first): start 0, direction bit, index[5:0], arg[31:0], CRC7[6:0], end 1. CRC7: poly x^7+x^3+1, init 0, over the first 40 bits.
- States:
  IDLE: cmd_oe=0; cmd_in=0 sampled -> RECEIVE (start bit counted as bit 47).
  RECEIVE: shift 47 more bits; after the end bit is sampled -> CHECK.
  CHECK (1 cycle): error if direction bit != 1, end bit != 1, or CRC mismatch. On error: cmd_error=1 for exactly this cycle -> IDLE, nothing delivered. Otherwise load cmd_index/cmd_arg -> DELIVER.
  DELIVER: cmd_strobe_out=1 (first asserted 2 cycles after the end-bit edge); hold until cmd_ack_in=1 sampled; strobe drops next cycle -> WAIT_RESP. cmd_index/cmd_arg hold until the next valid frame.
  WAIT_RESP: counter from 0; resp_strobe_in=1 -> latch resp_*; resp_none=1 -> DONE, else -> NCR. Counter reaching RESP_TIMEOUT without strobe -> IDLE silently.
  NCR: cmd_oe=0, cmd_out=1 for exactly NCR cycles -> SEND.
  SEND: cmd_oe=1 for exactly 48 cycles; frame = 0, direction 0, resp_index, resp_arg, CRC7 over first 40 bits, 1. Bit 47 on the first SEND cycle -> DONE.
  DONE (1 cycle): cmd_oe=0, cmd_out=1, resp_ack_out=1 -> IDLE.
- cmd_in is ignored outside IDLE/RECEIVE, including while cmd_oe=1.
- cmd_ack_in outside DELIVER and resp_strobe_in outside WAIT_RESP: ignored.
- cmd_ack_in asserted in the same cycle cmd_strobe_out first rises: accepted; strobe is high for 1 cycle only.
- Back-to-back: a start bit on the first IDLE cycle after DONE/error is captured.

Test Plan:
- CMD0: drive 0x40_0000_0000_95 serially -> cmd_strobe_out=1 2 cycles after end bit, cmd_index=0, cmd_arg=0, cmd_error=0; ack, then resp_none=1 -> resp_ack_out 1-cycle pulse, cmd_oe never 1.
- CMD17 arg 0 (0x51_0000_0000_55), respond resp_index=0x11, resp_arg=0x00000900 -> after NCR=2 idle cycles, cmd_oe=1 for 48 cycles, serial 0x11_0000_0900_67, then resp_ack_out pulse.
- CMD0 with CRC byte 0x97, then a second frame with end bit 0 -> cmd_error pulses once per frame, no cmd_strobe_out, FSM in IDLE.
- Valid command acked, resp_strobe_in withheld -> after 64 cycles back in IDLE, busy=0, no cmd_oe, next CMD0 accepted normally.
- Reset at bit 20 of SEND and abort_in during DELIVER -> cmd_oe=0, cmd_out=1, cmd_strobe_out=0 the next cycle; following CMD0 decoded correctly.
- Host-block loop: connect to the host CMD controller, issue CMD17 -> host receives response before its 136-cycle timeout, command_timeout=0.
